// File: rtl/life_pkg.sv
// Shared constants and helpers for the Game of Life engine.
package life_pkg;

  localparam int MV_UP = 0;
  localparam int MV_DN = 1;
  localparam int MV_LF = 2;
  localparam int MV_RT = 3;

  localparam int DEF_GRID_W   = 64;
  localparam int DEF_GRID_H   = 48;
  localparam int DEF_TICK_DIV = 12500000;
  localparam int DEF_MOVE_DIV = 10000;

  localparam int GEN_W = 16;

  // Flat bit index of cell (x,y) in a row-major array of width w.
  function automatic int idx(input int x, input int y, input int w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/life_core_if.sv
// Control inputs and display-facing outputs of life_core, bundled as one port.
interface life_core_if #(
  parameter int GRID_W = life_pkg::DEF_GRID_W,
  parameter int GRID_H = life_pkg::DEF_GRID_H
);
  import life_pkg::*;

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);

  logic                     freeze;
  logic                     step;
  logic                     toggle;
  logic [3:0]               move;
  logic [GRID_W*GRID_H-1:0] state;
  logic [XW-1:0]            cursor_x;
  logic [YW-1:0]            cursor_y;
  logic [GEN_W-1:0]         generation;
  logic                     tick;

  modport master (
    output freeze, step, toggle, move,
    input  state, cursor_x, cursor_y, generation, tick
  );

  modport slave (
    input  freeze, step, toggle, move,
    output state, cursor_x, cursor_y, generation, tick
  );

endinterface

// File: rtl/life_cell_next.sv
// B3/S23 next-state rule for a single cell given its eight neighbours.
module life_cell_next
  import life_pkg::*;
(
  input  logic [7:0] nbr_i,
  input  logic       cell_i,
  output logic       next_o
);

  logic [3:0] count;

  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, nbr_i[i]};
    end
  end

  assign next_o = (count == 4'd3) | (cell_i & (count == 4'd2));

endmodule

// File: rtl/life_core.sv
// Game of Life engine with tick/step advance, cursor and deferred toggle editing.
// Define LIFE_TORUS_EN for a toroidal grid; otherwise off-grid neighbours are dead.
module life_core
  import life_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int MOVE_DIV = DEF_MOVE_DIV,
  parameter logic [GRID_W*GRID_H-1:0] SEED = '0
) (
  input logic       clk,
  input logic       rst,
  life_core_if.slave bus
);

  localparam int N  = GRID_W * GRID_H;
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int CW = $clog2(N);
  localparam int TW = $clog2(TICK_DIV);
  localparam int MW = $clog2(MOVE_DIV);
  localparam int PW = GRID_W + 2;
  localparam int PH = GRID_H + 2;

  logic [N-1:0]       state_q;
  logic [N-1:0]       life_d;
  logic [N-1:0]       tog_mask;
  logic [PW*PH-1:0]   pad;
  logic [GEN_W-1:0]   gen_q;
  logic [TW-1:0]      tick_cnt_q;
  logic [MW-1:0]      move_cnt_q;
  logic               tick_q;
  logic               step_q;
  logic               toggle_q;
  logic               pend_q;
  logic [XW-1:0]      cursor_x_q, cursor_x_d;
  logic [YW-1:0]      cursor_y_q, cursor_y_d;
  logic [CW-1:0]      cur_idx;
  logic               step_pulse, tog_pulse, tog_req, advance;

  // Border ring around the grid: wrapped copies on a torus, dead cells otherwise.
  genvar gi, gj;
  for (gi = 0; gi < PH; gi++) begin : g_pad_row
    for (gj = 0; gj < PW; gj++) begin : g_pad_col
      localparam int SY = (gi == 0) ? GRID_H - 1 : (gi == PH - 1) ? 0 : gi - 1;
      localparam int SX = (gj == 0) ? GRID_W - 1 : (gj == PW - 1) ? 0 : gj - 1;
`ifdef LIFE_TORUS_EN
      assign pad[idx(gj, gi, PW)] = state_q[idx(SX, SY, GRID_W)];
`else
      if (gi > 0 && gi < PH - 1 && gj > 0 && gj < PW - 1) begin : g_in
        assign pad[idx(gj, gi, PW)] = state_q[idx(SX, SY, GRID_W)];
      end else begin : g_edge
        assign pad[idx(gj, gi, PW)] = 1'b0;
      end
`endif
    end
  end

  for (gi = 0; gi < GRID_H; gi++) begin : g_cell_row
    for (gj = 0; gj < GRID_W; gj++) begin : g_cell_col
      logic [7:0] nbr;
      assign nbr = {pad[idx(gj, gi, PW)],     pad[idx(gj + 1, gi, PW)],
                    pad[idx(gj + 2, gi, PW)], pad[idx(gj, gi + 1, PW)],
                    pad[idx(gj + 2, gi + 1, PW)], pad[idx(gj, gi + 2, PW)],
                    pad[idx(gj + 1, gi + 2, PW)], pad[idx(gj + 2, gi + 2, PW)]};
      life_cell_next u_cell (
        .nbr_i  (nbr),
        .cell_i (state_q[idx(gj, gi, GRID_W)]),
        .next_o (life_d[idx(gj, gi, GRID_W)])
      );
    end
  end

  assign step_pulse = bus.step & ~step_q;
  assign tog_pulse  = bus.toggle & ~toggle_q;
  assign tog_req    = tog_pulse | pend_q;
  assign advance    = (tick_q & ~bus.freeze) | (step_pulse & bus.freeze);
  assign cur_idx    = CW'(cursor_y_q) * CW'(GRID_W) + CW'(cursor_x_q);
  assign tog_mask   = {{(N-1){1'b0}}, 1'b1} << cur_idx;

  always_comb begin
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    if (bus.move[MV_UP] && !bus.move[MV_DN] && cursor_y_q != '0)
      cursor_y_d = cursor_y_q - YW'(1);
    if (bus.move[MV_DN] && !bus.move[MV_UP] && cursor_y_q != YW'(GRID_H - 1))
      cursor_y_d = cursor_y_q + YW'(1);
    if (bus.move[MV_LF] && !bus.move[MV_RT] && cursor_x_q != '0)
      cursor_x_d = cursor_x_q - XW'(1);
    if (bus.move[MV_RT] && !bus.move[MV_LF] && cursor_x_q != XW'(GRID_W - 1))
      cursor_x_d = cursor_x_q + XW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEED;
      gen_q      <= '0;
      tick_cnt_q <= '0;
      move_cnt_q <= '0;
      tick_q     <= 1'b0;
      step_q     <= 1'b0;
      toggle_q   <= 1'b0;
      pend_q     <= 1'b0;
      cursor_x_q <= '0;
      cursor_y_q <= '0;
    end else begin
      step_q     <= bus.step;
      toggle_q   <= bus.toggle;
      tick_cnt_q <= (tick_cnt_q == TW'(TICK_DIV - 1)) ? '0 : tick_cnt_q + TW'(1);
      // tick is high exactly while the counter sits at its terminal value
      tick_q     <= (tick_cnt_q == TW'(TICK_DIV - 2));
      move_cnt_q <= (move_cnt_q == MW'(MOVE_DIV - 1)) ? '0 : move_cnt_q + MW'(1);

      if (advance) begin
        state_q <= life_d;
        gen_q   <= gen_q + GEN_W'(1);
        pend_q  <= tog_req;
      end else begin
        if (tog_req)
          state_q <= state_q ^ tog_mask;
        pend_q <= 1'b0;
      end

      if (move_cnt_q == MW'(MOVE_DIV - 1)) begin
        cursor_x_q <= cursor_x_d;
        cursor_y_q <= cursor_y_d;
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.generation = gen_q;
  assign bus.cursor_x   = cursor_x_q;
  assign bus.cursor_y   = cursor_y_q;
  assign bus.tick       = tick_q;

endmodule

// File: tb/tb_life_core.sv
// Randomised and directed checks of life_core against a cell-array reference model.
module tb_life_core;
  import life_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int TD = 4;
  localparam int MD = 3;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  life_core_if #(.GRID_W(W), .GRID_H(H)) bus ();

  life_core #(
    .GRID_W   (W),
    .GRID_H   (H),
    .TICK_DIV (TD),
    .MOVE_DIV (MD),
    .SEED     ({N{1'b0}})
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  bit cells [H][W];
  int tcnt, mcnt, cx, cy, gen;
  bit sprev, tprev, pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_model();
    logic [63:0] v = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        v[y * W + x] = cells[y][x];
    return v;
  endfunction

  function automatic logic [63:0] pattern(input int xs[], input int ys[]);
    logic [63:0] v = '0;
    for (int i = 0; i < xs.size(); i++) v[ys[i] * W + xs[i]] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        cells[y][x] = 1'b0;
    tcnt = 0; mcnt = 0; cx = 0; cy = 0; gen = 0;
    sprev = 0; tprev = 0; pend = 0;
  endtask

  task automatic model_life();
    bit nxt [H][W];
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int c;
        c = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            nx = x + dx;
            ny = y + dy;
            if (dx == 0 && dy == 0) continue;
`ifdef LIFE_TORUS_EN
            nx = (nx + W) % W;
            ny = (ny + H) % H;
`else
            if (nx < 0 || nx >= W || ny < 0 || ny >= H) continue;
`endif
            c += int'(cells[ny][nx]);
          end
        end
        nxt[y][x] = (c == 3) || (cells[y][x] && c == 2);
      end
    end
    cells = nxt;
  endtask

  // One clock: apply the rules to the inputs currently driven, then compare.
  task automatic cycle();
    bit tick_now, sp, tp, adv, up, dn, lf, rt;
    tick_now = (tcnt == TD - 1);
    sp  = bus.step && !sprev;
    tp  = bus.toggle && !tprev;
    adv = (tick_now && !bus.freeze) || (sp && bus.freeze);
    if (adv) begin
      model_life();
      gen  = (gen + 1) % 65536;
      pend = pend || tp;
    end else if (tp || pend) begin
      cells[cy][cx] = !cells[cy][cx];
      pend = 0;
    end
    if (mcnt == MD - 1) begin
      up = bus.move[MV_UP]; dn = bus.move[MV_DN];
      lf = bus.move[MV_LF]; rt = bus.move[MV_RT];
      if (up && !dn && cy > 0)     cy--;
      if (dn && !up && cy < H - 1) cy++;
      if (lf && !rt && cx > 0)     cx--;
      if (rt && !lf && cx < W - 1) cx++;
    end
    tcnt  = (tcnt + 1) % TD;
    mcnt  = (mcnt + 1) % MD;
    sprev = bus.step;
    tprev = bus.toggle;
    @(posedge clk);
    #1;
    chk("state", bus.state, pack_model());
    chk("generation", bus.generation, 64'(gen));
    chk("cursor_x", bus.cursor_x, 64'(cx));
    chk("cursor_y", bus.cursor_y, 64'(cy));
    chk("tick", bus.tick, 64'(tcnt == TD - 1));
  endtask

  task automatic do_reset();
    bus.freeze = 0; bus.step = 0; bus.toggle = 0; bus.move = 4'b0000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic goto(input int x, input int y);
    for (int i = 0; i < 200 && !(cx == x && cy == y); i++) begin
      bus.move = 4'b0000;
      if (cy > y) bus.move[MV_UP] = 1'b1;
      if (cy < y) bus.move[MV_DN] = 1'b1;
      if (cx > x) bus.move[MV_LF] = 1'b1;
      if (cx < x) bus.move[MV_RT] = 1'b1;
      cycle();
    end
    bus.move = 4'b0000;
    chk("goto_x", bus.cursor_x, 64'(x));
    chk("goto_y", bus.cursor_y, 64'(y));
  endtask

  task automatic toggle_at(input int x, input int y);
    goto(x, y);
    bus.toggle = 1'b1;
    cycle();
    bus.toggle = 1'b0;
    cycle();
  endtask

  task automatic run_to_gen(input int g);
    for (int i = 0; i < 20 * TD * (g + 1) && gen < g; i++) cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] saved;
    int          gsave;
    bus.freeze = 0; bus.step = 0; bus.toggle = 0; bus.move = 4'b0000;

    // asynchronous reset takes effect without a clock edge
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_state", bus.state, 64'd0);
    chk("rst_gen", bus.generation, 64'd0);
    chk("rst_cx", bus.cursor_x, 64'd0);
    chk("rst_cy", bus.cursor_y, 64'd0);
    chk("rst_tick", bus.tick, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // blinker: horizontal at row 3, cols 2..4
    bus.freeze = 1'b1;
    toggle_at(2, 3); toggle_at(3, 3); toggle_at(4, 3);
    chk("blk_load", bus.state, pattern('{2, 3, 4}, '{3, 3, 3}));
    bus.freeze = 1'b0;
    run_to_gen(1);
    chk("blk_gen1_state", bus.state, pattern('{3, 3, 3}, '{2, 3, 4}));
    chk("blk_gen1", bus.generation, 64'd1);
    run_to_gen(2);
    chk("blk_gen2_state", bus.state, pattern('{2, 3, 4}, '{3, 3, 3}));
    chk("blk_gen2", bus.generation, 64'd2);
    $display("[TB] blinker gen=%0d", bus.generation);

    // freeze holds everything, then a long step press advances once
    bus.freeze = 1'b1;
    saved = pack_model();
    gsave = gen;
    repeat (20) cycle();
    chk("frz_state", bus.state, saved);
    chk("frz_gen", bus.generation, 64'(gsave));
    bus.step = 1'b1;
    cycle();
    chk("step_gen_1cyc", bus.generation, 64'(gsave + 1));
    repeat (9) cycle();
    bus.step = 1'b0;
    cycle();
    chk("step_once", bus.generation, 64'(gsave + 1));
    $display("[TB] step gen=%0d", bus.generation);

    // cursor saturation
    goto(0, 0);
    bus.move = 4'b0101;
    repeat (5 * MD) cycle();
    chk("sat_ul_x", bus.cursor_x, 64'd0);
    chk("sat_ul_y", bus.cursor_y, 64'd0);
    bus.move = 4'b1000;
    repeat (10 * MD) cycle();
    chk("sat_rt_x", bus.cursor_x, 64'd7);
    bus.move = 4'b0000;
    $display("[TB] cursor (%0d,%0d)", bus.cursor_x, bus.cursor_y);

    // toggle coincident with an advance is deferred by one cycle
    do_reset();
    goto(2, 2);
    for (int i = 0; i < TD + 1 && tcnt != TD - 1; i++) cycle();
    gsave = gen;
    bus.toggle = 1'b1;
    cycle();
    chk("defer_adv_state", bus.state, 64'd0);
    chk("defer_adv_gen", bus.generation, 64'(gsave + 1));
    bus.toggle = 1'b0;
    cycle();
    chk("defer_cell", bus.state, pattern('{2}, '{2}));
    $display("[TB] deferred toggle state=%h", bus.state);

    // glider heading south-east across the east edge
    do_reset();
    bus.freeze = 1'b1;
    toggle_at(5, 1); toggle_at(6, 2); toggle_at(4, 3); toggle_at(5, 3); toggle_at(6, 3);
    bus.freeze = 1'b0;
    run_to_gen(12);
    chk("glider_gen", bus.generation, 64'd12);
`ifdef LIFE_TORUS_EN
    chk("glider_wrap", bus.state, pattern('{0, 1, 7, 0, 1}, '{4, 5, 6, 6, 6}));
`endif
    run_to_gen(20);
    $display("[TB] glider gen=%0d state=%h", bus.generation, bus.state);

    // random operation
    for (int i = 0; i < 600; i++) begin
      bus.freeze = 1'($urandom_range(0, 1));
      bus.step   = ($urandom_range(0, 2) == 0);
      bus.toggle = ($urandom_range(0, 2) == 0);
      bus.move   = 4'($urandom_range(0, 15));
      cycle();
    end
    bus.step = 0; bus.toggle = 0; bus.move = 4'b0000;
    $display("[TB] random run gen=%0d", bus.generation);

    // reset mid-run
    do_reset();
    goto(5, 4);
    bus.toggle = 1'b1; cycle(); bus.toggle = 1'b0; cycle();
    run_to_gen(37);
    chk("pre_rst_gen", bus.generation, 64'd37);
    chk("pre_rst_cx", bus.cursor_x, 64'd5);
    chk("pre_rst_cy", bus.cursor_y, 64'd4);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_state", bus.state, 64'd0);
    chk("midrst_gen", bus.generation, 64'd0);
    chk("midrst_cx", bus.cursor_x, 64'd0);
    chk("midrst_cy", bus.cursor_y, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3 * TD) cycle();
    $display("[TB] after reset gen=%0d", bus.generation);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
